// File: rtl/bsg_mem_one_hot_byte_write_arb.sv
// rtl/bsg_mem_one_hot_byte_write_arb.sv - write-port arbiter and one-hot decoder for a 1r1w byte-masked register file
//
// Two requesters share the single write port through valid/ready handshakes with
// round-robin priority. Accepted writes are decoded to one-hot and registered
// into the memory one cycle later. After every reset an init sweep zeroes all
// entries before any requester is accepted.
//
// Optional macro BSG_MEM_ONE_HOT_BYTE_WRITE_ARB_MERGE_EN: grants both requesters in
// the same cycle when they target the same in-range entry with disjoint masks.
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   w_v_i          per-requester write valid
//   w_ready_o      per-requester grant (handshake = w_v_i & w_ready_o)
//   w_addr_i       per-requester binary address, requester k at [k*addr_width_lp +: addr_width_lp]
//   w_data_i       per-requester write data
//   w_mask_i       per-requester byte mask
//   r_addr_i       read address
//   mem_w_v_o      registered one/zero-hot write select
//   mem_w_data_o   registered write data
//   mem_w_mask_o   registered byte mask
//   mem_r_v_o      combinational one/zero-hot read select
//   init_done_o    high once the init sweep has completed
//   err_o          sticky, set by an accepted out-of-range write
module bsg_mem_one_hot_byte_write_arb #(
   parameter int width_p       = 32,
   parameter int els_p         = 16,
   parameter int mask_width_lp = width_p >> 3,
   parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [1:0]                   w_v_i,
   output logic [1:0]                   w_ready_o,
   input  logic [2*addr_width_lp-1:0]   w_addr_i,
   input  logic [2*width_p-1:0]         w_data_i,
   input  logic [2*mask_width_lp-1:0]   w_mask_i,
   input  logic [addr_width_lp-1:0]     r_addr_i,
   output logic [els_p-1:0]             mem_w_v_o,
   output logic [width_p-1:0]           mem_w_data_o,
   output logic [mask_width_lp-1:0]     mem_w_mask_o,
   output logic [els_p-1:0]             mem_r_v_o,
   output logic                         init_done_o,
   output logic                         err_o
);

   typedef enum logic {INIT, RUN} state_e;

   localparam logic [addr_width_lp-1:0] last_entry = addr_width_lp'(els_p - 1);

   state_e                    state;
   logic [addr_width_lp-1:0]  count;
   logic                      ptr;

   logic [addr_width_lp-1:0]  addr0, addr1, sel_addr;
   logic [width_p-1:0]        data0, data1, sel_data;
   logic [mask_width_lp-1:0]  mask0, mask1, sel_mask;
   logic [els_p-1:0]          sel_onehot;
   logic [1:0]                grant;
   logic                      merge;
   logic                      flip;

   // Addresses at or beyond els_p decode to all zeros.
   function automatic logic [els_p-1:0] decode(input logic [addr_width_lp-1:0] a);
      logic [els_p-1:0] d;
      d = '0;
      for (int i = 0; i < els_p; i++) begin
         d[i] = (a == addr_width_lp'(i));
      end
      return d;
   endfunction

   assign addr0 = w_addr_i[0 +: addr_width_lp];
   assign addr1 = w_addr_i[addr_width_lp +: addr_width_lp];
   assign data0 = w_data_i[0 +: width_p];
   assign data1 = w_data_i[width_p +: width_p];
   assign mask0 = w_mask_i[0 +: mask_width_lp];
   assign mask1 = w_mask_i[mask_width_lp +: mask_width_lp];

`ifdef BSG_MEM_ONE_HOT_BYTE_WRITE_ARB_MERGE_EN
   assign merge = (state == RUN) && (w_v_i == 2'b11) && (addr0 == addr1)
                  && (|decode(addr0)) && ((mask0 & mask1) == '0);
`else
   assign merge = 1'b0;
`endif

   // Grant only looks at the valids and the pointer, never at the other ready.
   always_comb begin
      grant    = 2'b00;
      flip     = 1'b0;
      sel_addr = addr0;
      sel_data = data0;
      sel_mask = mask0;
      if (state == RUN) begin
         if (merge) begin
            grant = 2'b11;
         end else if (w_v_i == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
            flip  = 1'b1;
         end else begin
            grant = w_v_i;
         end
      end
      if (merge) begin
         // Disjoint masks: each byte comes from whichever requester owns it.
         sel_mask = mask0 | mask1;
         for (int b = 0; b < mask_width_lp; b++) begin
            sel_data[8*b +: 8] = mask1[b] ? data1[8*b +: 8] : data0[8*b +: 8];
         end
      end else if (grant[1]) begin
         sel_addr = addr1;
         sel_data = data1;
         sel_mask = mask1;
      end
   end

   assign sel_onehot = decode(sel_addr);
   assign w_ready_o  = grant;
   assign mem_r_v_o  = decode(r_addr_i);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= INIT;
         count        <= '0;
         ptr          <= 1'b0;
         mem_w_v_o    <= '0;
         mem_w_data_o <= '0;
         mem_w_mask_o <= '0;
         init_done_o  <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               mem_w_v_o    <= decode(count);
               mem_w_data_o <= '0;
               mem_w_mask_o <= '1;
               if (count == last_entry) begin
                  state       <= RUN;
                  init_done_o <= 1'b1;
               end else begin
                  count <= count + addr_width_lp'(1);
               end
            end
            RUN: begin
               mem_w_v_o <= (|grant) ? sel_onehot : '0;
               if (|grant) begin
                  mem_w_data_o <= sel_data;
                  mem_w_mask_o <= sel_mask;
                  // Accepted but out of range: nothing is written, flag it.
                  if (sel_onehot == '0) begin
                     err_o <= 1'b1;
                  end
               end
               if (flip) begin
                  ptr <= ~ptr;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_mem_one_hot_byte_write_arb.sv
// tb/tb_bsg_mem_one_hot_byte_write_arb.sv - randomized model-checked bench for bsg_mem_one_hot_byte_write_arb
module tb_bsg_mem_one_hot_byte_write_arb;

   localparam int ELS = 12;
   localparam int W   = 32;
   localparam int MW  = 4;
   localparam int AW  = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      w_v;
   logic [1:0]      w_ready;
   logic [2*AW-1:0] w_addr;
   logic [2*W-1:0]  w_data;
   logic [2*MW-1:0] w_mask;
   logic [AW-1:0]   r_addr;
   logic [ELS-1:0]  mem_w_v;
   logic [W-1:0]    mem_w_data;
   logic [MW-1:0]   mem_w_mask;
   logic [ELS-1:0]  mem_r_v;
   logic            init_done;
   logic            err;

   int n_vec = 0;
   int n_err = 0;

   // model state
   int             seen;
   bit             ptr;
   logic [ELS-1:0] exp_v;
   logic [W-1:0]   exp_d;
   logic [MW-1:0]  exp_m;
   logic           exp_done;
   logic           exp_err;
   logic [W-1:0]   mmem [ELS];
   logic [W-1:0]   ram  [ELS];

   bsg_mem_one_hot_byte_write_arb #(.width_p(W), .els_p(ELS)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .w_v_i(w_v), .w_ready_o(w_ready),
      .w_addr_i(w_addr), .w_data_i(w_data), .w_mask_i(w_mask), .r_addr_i(r_addr),
      .mem_w_v_o(mem_w_v), .mem_w_data_o(mem_w_data), .mem_w_mask_o(mem_w_mask),
      .mem_r_v_o(mem_r_v), .init_done_o(init_done), .err_o(err)
   );

   always #5 clk = ~clk;

   // The register file driven by the controller: async read, byte-masked write.
   always @(posedge clk) begin
      for (int i = 0; i < ELS; i++) begin
         if (mem_w_v[i]) begin
            for (int b = 0; b < MW; b++) begin
               if (mem_w_mask[b]) ram[i][8*b +: 8] <= mem_w_data[8*b +: 8];
            end
         end
      end
   end

   function automatic logic [W-1:0] rd();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < ELS; i++) if (mem_r_v[i]) r = r | ram[i];
      return r;
   endfunction

   function automatic logic [ELS-1:0] onehot(input int a);
      logic [ELS-1:0] one;
      one = ELS'(1);
      return (a >= 0 && a < ELS) ? (one << a) : '0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic hold_reset_and_release();
      rst_n = 1'b0;
      w_v   = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_w_v", 64'(mem_w_v), 64'h0);
      chk("rst_mem_w_data", 64'(mem_w_data), 64'h0);
      chk("rst_mem_w_mask", 64'(mem_w_mask), 64'h0);
      chk("rst_w_ready", 64'(w_ready), 64'h0);
      chk("rst_init_done", 64'(init_done), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      rst_n    = 1'b1;
      seen     = 0;
      ptr      = 1'b0;
      exp_v    = onehot(0);
      exp_d    = '0;
      exp_m    = '1;
      exp_done = (ELS <= 1);
      exp_err  = 1'b0;
   endtask

   // One clock of stimulus plus checks against the model.
   task automatic cycle(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [MW-1:0] m0, input logic [MW-1:0] m1, input logic [AW-1:0] ra);
      logic [1:0]     g;
      logic [ELS-1:0] nv;
      logic [W-1:0]   nd;
      logic [MW-1:0]  nm;
      logic [AW-1:0]  na;
      bit             ne;
      bit             mergeable;
      @(negedge clk);
      seen++;
      chk("mem_w_v", 64'(mem_w_v), 64'(exp_v));
      if (exp_v != '0) begin
         chk("mem_w_data", 64'(mem_w_data), 64'(exp_d));
         chk("mem_w_mask", 64'(mem_w_mask), 64'(exp_m));
      end
      chk("init_done", 64'(init_done), 64'(exp_done));
      chk("err", 64'(err), 64'(exp_err));
      w_v    = v;
      w_addr = {a1, a0};
      w_data = {d1, d0};
      w_mask = {m1, m0};
      r_addr = ra;
      #1;
      chk("mem_r_v", 64'(mem_r_v), 64'(onehot(int'(ra))));
      if (int'(ra) < ELS) chk("rdata", 64'(rd()), 64'(mmem[ra]));
      // the write shown this cycle lands at the coming edge
      for (int i = 0; i < ELS; i++) begin
         if (exp_v[i]) begin
            for (int b = 0; b < MW; b++) if (exp_m[b]) mmem[i][8*b +: 8] = exp_d[8*b +: 8];
         end
      end
      g  = 2'b00;
      ne = 1'b0;
      nv = '0;
      nd = '0;
      nm = '0;
      na = a0;
      if (seen < ELS) begin
         chk("w_ready_init", 64'(w_ready), 64'h0);
         nv = onehot(seen);
         nm = '1;
      end else begin
         mergeable = 1'b0;
`ifdef BSG_MEM_ONE_HOT_BYTE_WRITE_ARB_MERGE_EN
         mergeable = (a0 == a1) && (int'(a0) < ELS) && ((m0 & m1) == '0);
`endif
         if (v == 2'b11 && mergeable) begin
            g  = 2'b11;
            nm = m0 | m1;
            for (int b = 0; b < MW; b++) nd[8*b +: 8] = m1[b] ? d1[8*b +: 8] : d0[8*b +: 8];
         end else if (v == 2'b11) begin
            g   = ptr ? 2'b10 : 2'b01;
            ptr = !ptr;
         end else begin
            g = v;
         end
         chk("w_ready", 64'(w_ready), 64'(g));
         if (g == 2'b01) begin na = a0; nd = d0; nm = m0; end
         if (g == 2'b10) begin na = a1; nd = d1; nm = m1; end
         if (g != 2'b00) begin
            if (int'(na) < ELS) nv = onehot(int'(na));
            else ne = 1'b1;
         end
      end
      exp_v    = nv;
      exp_d    = nd;
      exp_m    = nm;
      exp_done = (seen + 1 >= ELS);
      exp_err  = exp_err | ne;
   endtask

   task automatic idle(input logic [AW-1:0] ra);
      cycle(2'b00, '0, '0, '0, '0, '0, '0, ra);
   endtask

   task automatic rand_cycle();
      logic [AW-1:0] a0, a1;
      a0 = AW'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 15));
      cycle(2'($urandom), a0, a1, $urandom, $urandom, 4'($urandom), 4'($urandom),
            AW'($urandom_range(0, 15)));
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] v2;
      for (int i = 0; i < ELS; i++) begin
         mmem[i] = 32'hA5A50000 | i;
         ram[i]  = 32'hA5A50000 | i;
      end
      w_addr = '0; w_data = '0; w_mask = '0; r_addr = '0;
      hold_reset_and_release();

      // init sweep walks entries 0..ELS-1
      for (int i = 0; i < ELS; i++) begin
         idle(AW'(i));
         if (i == 3) chk("init_walk_lit", 64'(mem_w_v), 64'h008);
      end
      chk("init_done_lit", 64'(init_done), 64'h1);

      // single byte-masked write
      cycle(2'b01, 4'd3, 4'd0, 32'hAABBCCDD, '0, 4'b0101, '0, 4'd0);
      idle(4'd0);
      chk("wr3_v_lit", 64'(mem_w_v), 64'h008);
      chk("wr3_mask_lit", 64'(mem_w_mask), 64'h5);
      idle(4'd3);
      chk("wr3_read_lit", 64'(rd()), 64'h00BB00DD);

      // both valid: grants alternate starting with requester 0
      for (int i = 0; i < 4; i++) begin
         cycle(2'b11, 4'd1, 4'd2, $urandom, $urandom, 4'hF, 4'hF, 4'd1);
         chk("rr_lit", 64'(w_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      end
      idle(4'd2);

      // same address, disjoint masks
      cycle(2'b11, 4'd5, 4'd5, 32'h11111111, 32'h22222222, 4'b0011, 4'b1100, 4'd0);
`ifdef BSG_MEM_ONE_HOT_BYTE_WRITE_ARB_MERGE_EN
      chk("merge_ready_lit", 64'(w_ready), 64'h3);
      v2 = 2'b00;
`else
      chk("merge_ready_lit", 64'(w_ready), 64'h1);
      v2 = 2'b10;
`endif
      cycle(v2, 4'd5, 4'd5, 32'h11111111, 32'h22222222, 4'b0011, 4'b1100, 4'd0);
      idle(4'd5);
      idle(4'd5);
      chk("merge_read_lit", 64'(rd()), 64'h22221111);

      // out-of-range write
      cycle(2'b10, 4'd0, 4'd13, '0, 32'h12345678, '0, 4'hF, 4'd0);
      idle(4'd13);
      chk("oor_v_lit", 64'(mem_w_v), 64'h0);
      chk("oor_err_lit", 64'(err), 64'h1);
      chk("oor_rv_lit", 64'(mem_r_v), 64'h0);
      idle(4'd0);
      chk("oor_sticky_lit", 64'(err), 64'h1);

      repeat (3000) rand_cycle();

      // reset with a handshake in flight
      idle(4'd0);
      cycle(2'b11, 4'd7, 4'd8, $urandom, $urandom, 4'hF, 4'hF, 4'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_v_lit", 64'(mem_w_v), 64'h0);
      @(posedge clk);
      #1;
      chk("abort_after_edge_lit", 64'(mem_w_v), 64'h0);
      hold_reset_and_release();
      idle(4'd0);
      chk("reinit_first_lit", 64'(mem_w_v), 64'h001);
      repeat (600) rand_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
